imem_prog: RTL

Parametrised, field-programmable instruction memory that replaces the fixed 8K×17 hex-initialised instruction store. It keeps a registered CPU fetch port and adds a byte-serial programming port, fed by the UART receive path, which assembles bytes into instruction words and writes them at an auto-incrementing address. It also provides out-of-range address protection and optional per-word parity. It sits between the fetch stage and the boot/UART loader.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_byte_loader.sv | 116 +++++++++++
 rtl/imem_prog.sv | 120 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the programmable instruction memory.
// Holds the loader state type, the bytes-per-word helper and the default
// value returned for out-of-range fetches.
package imem_pkg;

   // Loader session states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FINISH = 2'd2
   } load_state_t;

   // Default fetch value for addresses beyond the populated depth.
   localparam int unsigned IMEM_NOP_DEFAULT = 0;

   // Number of programming bytes needed to carry one instruction word.
   function automatic int bpw(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/imem_byte_loader.sv
// Purpose: byte-serial loader; assembles MSB-first bytes into words and emits writes at an auto-incrementing address.
// Latency: write strobe is combinational in the cycle the last byte of a word is accepted; status outputs are registered.
// Backpressure: none; bytes are accepted every cycle byte_vld is high while in LOAD, otherwise ignored.
//
// Ports: clk/rst (sync, active-high); prog_en session level; byte_vld/byte_in byte stream;
//        busy, prog_done, prog_err, words_loaded status; wr_en/wr_addr/wr_data memory write port.
module imem_byte_loader
   import imem_pkg::*;
#(
   parameter int INSTR_W = 17,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 8192,
   parameter int MEM_AW  = 13
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_en,
   input  logic               byte_vld,
   input  logic [7:0]         byte_in,
   output logic               busy,
   output logic               prog_done,
   output logic               prog_err,
   output logic [ADDR_W:0]    words_loaded,
   output logic               wr_en,
   output logic [MEM_AW-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data
);

   localparam int BPW   = bpw(INSTR_W);
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   load_state_t        state;
   logic [CNT_W-1:0]   byte_cnt;
   logic [INSTR_W-1:0] asm_q;
   logic [ADDR_W:0]    load_addr;

   logic               accept;
   logic               last_byte;
   logic               room;
   logic [INSTR_W-1:0] asm_next;

   // Keeping only the low INSTR_W bits at every shift gives the same result
   // as assembling the full BPW*8-bit value and truncating at the end.
   assign asm_next  = INSTR_W'({asm_q, byte_in});
   assign accept    = (state == LOAD) && prog_en && byte_vld;
   assign last_byte = (byte_cnt == CNT_W'(BPW - 1));
   assign room      = (load_addr < DEPTH_C);

   assign wr_en   = accept && last_byte && room;
   assign wr_addr = load_addr[MEM_AW-1:0];
   assign wr_data = asm_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         asm_q        <= '0;
         load_addr    <= '0;
         words_loaded <= '0;
         prog_err     <= 1'b0;
         busy         <= 1'b0;
         prog_done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               prog_done <= 1'b0;
               if (prog_en) begin
                  state        <= LOAD;
                  busy         <= 1'b1;
                  byte_cnt     <= '0;
                  load_addr    <= '0;
                  words_loaded <= '0;
                  prog_err     <= 1'b0;
               end
            end
            LOAD: begin
               if (!prog_en) begin
                  // Session ends; any half-assembled word is dropped.
                  state     <= FINISH;
                  prog_done <= 1'b1;
                  byte_cnt  <= '0;
                  if (byte_cnt != '0) begin
                     prog_err <= 1'b1;
                  end
               end else if (byte_vld) begin
                  asm_q <= asm_next;
                  if (last_byte) begin
                     byte_cnt <= '0;
                     if (room) begin
                        load_addr    <= load_addr + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                     end else begin
                        // Memory full: word is dropped, count stays at DEPTH.
                        prog_err <= 1'b1;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            FINISH: begin
               state     <= IDLE;
               busy      <= 1'b0;
               prog_done <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               prog_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/imem_prog.sv
// Purpose: field-programmable instruction memory with a registered fetch port and a byte-serial programming port.
// Latency: fetch data and instr_vld one cycle after rd_en; loader writes land at the edge accepting a word's last byte.
// Backpressure: fetches are dropped (instr_vld=0, instr held) while the loader is busy or prog_en is high.
//
// Ports: clk/rst (sync, active-high); rd_en/addr -> instr/instr_vld/parity_err fetch port;
//        prog_en/byte_vld/byte_in programming input; busy/prog_done/prog_err/words_loaded loader status.
// Build option: define IMEM_PARITY_EN to store an even-parity bit per word and check it on fetch.
module imem_prog
   import imem_pkg::*;
#(
   parameter int INSTR_W = 17,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 8192,
   parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(IMEM_NOP_DEFAULT)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  addr,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_vld,
   input  logic               prog_en,
   input  logic               byte_vld,
   input  logic [7:0]         byte_in,
   output logic               busy,
   output logic               prog_done,
   output logic               prog_err,
   output logic [ADDR_W:0]    words_loaded,
   output logic               parity_err
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
`ifdef IMEM_PARITY_EN
   localparam int ENT_W = INSTR_W + 1;
`else
   localparam int ENT_W = INSTR_W;
`endif

   logic               wr_en;
   logic [MEM_AW-1:0]  wr_addr;
   logic [INSTR_W-1:0] wr_data;

   imem_byte_loader #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .MEM_AW  (MEM_AW)
   ) u_loader (
      .clk          (clk),
      .rst          (rst),
      .prog_en      (prog_en),
      .byte_vld     (byte_vld),
      .byte_in      (byte_in),
      .busy         (busy),
      .prog_done    (prog_done),
      .prog_err     (prog_err),
      .words_loaded (words_loaded),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   // Storage is deliberately left out of reset so a reset keeps the program.
   logic [ENT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
`ifdef IMEM_PARITY_EN
         mem[wr_addr] <= {^wr_data, wr_data};
`else
         mem[wr_addr] <= wr_data;
`endif
      end
   end

   logic             fetch_ok;
   logic             in_range;
   logic [ENT_W-1:0] rd_word;

   // busy is high exactly when the loader is outside IDLE, so together with
   // prog_en low it marks the cycles where the array belongs to the fetch port.
   assign fetch_ok = rd_en && !busy && !prog_en;
   assign in_range = ({1'b0, addr} < DEPTH_C);
   assign rd_word  = mem[addr[MEM_AW-1:0]];

`ifdef IMEM_PARITY_EN
   logic parity_err_q;
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         instr     <= NOP_WORD;
         instr_vld <= 1'b0;
`ifdef IMEM_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         instr_vld <= fetch_ok;
`ifdef IMEM_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         if (fetch_ok) begin
            if (in_range) begin
               instr <= rd_word[INSTR_W-1:0];
`ifdef IMEM_PARITY_EN
               // Even parity over data plus stored bit must reduce to 0.
               parity_err_q <= ^rd_word;
`endif
            end else begin
               instr <= NOP_WORD;
            end
         end
      end
   end

endmodule
